// File: rtl/param_topk_voter.sv
// Streaming top-K nearest-neighbour list with a majority vote over the retained labels.
// Candidates are insertion-sorted on acceptance; the vote then scans one rank per cycle.
module param_topk_voter #(
    parameter int unsigned K       = 5,
    parameter int unsigned DIST_W  = 18,
    parameter int unsigned LABEL_W = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           valid_in,
    input  logic [DIST_W-1:0]              dist_in,
    input  logic [LABEL_W-1:0]             label_in,
    input  logic                           last_in,
    output logic                           in_ready,
    output logic [K*(DIST_W+LABEL_W)-1:0]  sorted_list,
    output logic [4:0]                     count,
    output logic [LABEL_W-1:0]             result_label,
    output logic                           done
);

    localparam int unsigned ENT_W   = DIST_W + LABEL_W;
    localparam int unsigned NUM_LBL = 1 << LABEL_W;
    localparam logic [4:0]  K5      = 5'(K);
    localparam logic [4:0]  KM1     = 5'(K - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] VOTE    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]         state;
    logic [DIST_W-1:0]  dist_q    [K];
    logic [LABEL_W-1:0] label_q   [K];
    logic [DIST_W-1:0]  nxt_dist  [K];
    logic [LABEL_W-1:0] nxt_label [K];
    logic [4:0]         count_q;
    logic [4:0]         scan_idx;
    logic [4:0]         vote_cnt  [NUM_LBL];
    logic [4:0]         best_cnt;
    logic [LABEL_W-1:0] best_label;
    logic [LABEL_W-1:0] result_q;

    logic [4:0]         ins_pos;
    logic               found;
    logic [LABEL_W-1:0] cur_label;
    logic               scan_valid;
    logic [4:0]         vote_inc;
    logic               take;
    logic [LABEL_W-1:0] win_label;

    // Strict '<' places a new entry behind any equal distance, keeping ties in arrival order.
    always_comb begin
        ins_pos = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < K; i++) begin
            if (!found && ((5'(i) >= count_q) || (dist_in < dist_q[i]))) begin
                ins_pos = 5'(i);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            nxt_dist[i]  = dist_q[i];
            nxt_label[i] = label_q[i];
        end
        if (found && (ins_pos == 5'd0)) begin
            nxt_dist[0]  = dist_in;
            nxt_label[0] = label_in;
        end
        for (int unsigned i = 1; i < K; i++) begin
            if (found && (5'(i) == ins_pos)) begin
                nxt_dist[i]  = dist_in;
                nxt_label[i] = label_in;
            end else if (found && (5'(i) > ins_pos)) begin
                nxt_dist[i]  = dist_q[i-1];
                nxt_label[i] = label_q[i-1];
            end
        end
    end

    always_comb begin
        cur_label = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (5'(i) == scan_idx) begin
                cur_label = label_q[i];
            end
        end
        scan_valid = (scan_idx < count_q);
        vote_inc   = vote_cnt[cur_label] + 5'd1;
        take       = scan_valid && (vote_inc > best_cnt);
        win_label  = take ? cur_label : best_label;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count_q    <= '0;
            scan_idx   <= '0;
            best_cnt   <= '0;
            best_label <= '0;
            result_q   <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i]  <= '1;
                label_q[i] <= '0;
            end
            for (int unsigned l = 0; l < NUM_LBL; l++) begin
                vote_cnt[l] <= '0;
            end
        end else if (start) begin
            state      <= COLLECT;
            count_q    <= '0;
            scan_idx   <= '0;
            best_cnt   <= '0;
            best_label <= '0;
            result_q   <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i]  <= '1;
                label_q[i] <= '0;
            end
            for (int unsigned l = 0; l < NUM_LBL; l++) begin
                vote_cnt[l] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (valid_in) begin
                        for (int unsigned i = 0; i < K; i++) begin
                            dist_q[i]  <= nxt_dist[i];
                            label_q[i] <= nxt_label[i];
                        end
                        if (count_q < K5) begin
                            count_q <= count_q + 5'd1;
                        end
                        if (last_in) begin
                            state <= VOTE;
                        end
                    end
                end
                VOTE: begin
                    if (scan_valid) begin
                        vote_cnt[cur_label] <= vote_inc;
                    end
                    if (take) begin
                        best_cnt   <= vote_inc;
                        best_label <= cur_label;
                    end
                    // The last rank's vote is folded in combinationally so result_label is final in DONE.
                    if (scan_idx == KM1) begin
                        state    <= DONE;
                        result_q <= win_label;
                    end else begin
                        scan_idx <= scan_idx + 5'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_pack
        assign sorted_list[g*ENT_W +: ENT_W] = {dist_q[g], label_q[g]};
    end

    assign in_ready     = (state == COLLECT);
    assign done         = (state == DONE);
    assign count        = count_q;
    assign result_label = result_q;

endmodule

// File: tb/tb_param_topk_voter.sv
// Directed bench for param_topk_voter at K=5, DIST_W=18, LABEL_W=2 with hand-computed expectations.
module tb_param_topk_voter;

    localparam int unsigned K  = 5;
    localparam int unsigned DW = 18;
    localparam int unsigned LW = 2;
    localparam int unsigned EW = DW + LW;

    localparam logic [EW-1:0] EMPTY = {{DW{1'b1}}, {LW{1'b0}}};
    localparam logic [DW-1:0] DMAX  = {DW{1'b1}};

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              valid_in;
    logic [DW-1:0]     dist_in;
    logic [LW-1:0]     label_in;
    logic              last_in;
    logic              in_ready;
    logic [K*EW-1:0]   sorted_list;
    logic [4:0]        count;
    logic [LW-1:0]     result_label;
    logic              done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_topk_voter #(.K(K), .DIST_W(DW), .LABEL_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .valid_in     (valid_in),
        .dist_in      (dist_in),
        .label_in     (label_in),
        .last_in      (last_in),
        .in_ready     (in_ready),
        .sorted_list  (sorted_list),
        .count        (count),
        .result_label (result_label),
        .done         (done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [DW-1:0] d, input logic [LW-1:0] l);
        return {d, l};
    endfunction

    function automatic logic [K*EW-1:0] lst(input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                                            input logic [EW-1:0] e2, input logic [EW-1:0] e3,
                                            input logic [EW-1:0] e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic last);
        @(negedge clk);
        check("in_ready_at_send", in_ready, 1);
        valid_in = 1'b1;
        dist_in  = d;
        label_in = l;
        last_in  = last;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    // Cycle 1 is the one that begins at the accepting edge; done must first appear in cycle K+1.
    task automatic wait_done(input string tag, input int exp_n, input logic [LW-1:0] exp_label);
        int n;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        check({tag, "_latency"}, n, exp_n);
        check({tag, "_label_at_done"}, result_label, exp_label);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int seen;
        rst      = 1'b0;
        start    = 1'b0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        dist_in  = '0;
        label_in = '0;

        // Asynchronous reset, checked before any clock edge has occurred.
        #2 rst = 1'b1;
        #1;
        check("rst_list", sorted_list, lst(EMPTY, EMPTY, EMPTY, EMPTY, EMPTY));
        check("rst_count", count, 0);
        check("rst_result", result_label, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // valid_in in IDLE is ignored.
        @(negedge clk);
        valid_in = 1'b1; dist_in = 18'd3; label_in = 2'd1; last_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0; last_in = 1'b0;
        check("idle_ignore_count", count, 0);
        check("idle_ignore_list", sorted_list, lst(EMPTY, EMPTY, EMPTY, EMPTY, EMPTY));

        // Full query: 90 is pushed out by 30.
        do_start();
        check("start_in_ready", in_ready, 1);
        check("start_count", count, 0);
        send(18'd50, 2'd1, 1'b0);
        check("q1_first_insert", sorted_list, lst(ent(50, 1), EMPTY, EMPTY, EMPTY, EMPTY));
        send(18'd20, 2'd2, 1'b0);
        send(18'd90, 2'd1, 1'b0);
        send(18'd10, 2'd3, 1'b0);
        send(18'd70, 2'd2, 1'b0);
        check("q1_full_list", sorted_list, lst(ent(10, 3), ent(20, 2), ent(50, 1), ent(70, 2), ent(90, 1)));
        send(18'd30, 2'd0, 1'b1);
        check("q1_list", sorted_list, lst(ent(10, 3), ent(20, 2), ent(30, 0), ent(50, 1), ent(70, 2)));
        check("q1_count", count, 5);
        wait_done("q1", 6, 2'd2);
        check("q1_idle_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("q1_result_held", result_label, 2);

        // Equal distances keep arrival order; the tie goes to the first label to reach it.
        do_start();
        send(18'd20, 2'd1, 1'b0);
        send(18'd20, 2'd2, 1'b1);
        check("tie_list", sorted_list, lst(ent(20, 1), ent(20, 2), EMPTY, EMPTY, EMPTY));
        check("tie_count", count, 2);
        wait_done("tie", 6, 2'd1);

        // Partial list.
        do_start();
        send(18'd5, 2'd1, 1'b0);
        send(18'd6, 2'd2, 1'b0);
        send(18'd7, 2'd2, 1'b1);
        check("part_list", sorted_list, lst(ent(5, 1), ent(6, 2), ent(7, 2), EMPTY, EMPTY));
        check("part_count", count, 3);
        wait_done("part", 6, 2'd2);

        // Maximum distance still occupies an empty rank.
        do_start();
        send(DMAX, 2'd3, 1'b1);
        check("max_list", sorted_list, lst(ent(DMAX, 3), EMPTY, EMPTY, EMPTY, EMPTY));
        check("max_count", count, 1);
        wait_done("max", 6, 2'd3);

        // Restart mid-COLLECT, with start and valid_in together: start wins.
        do_start();
        send(18'd40, 2'd1, 1'b0);
        send(18'd30, 2'd2, 1'b0);
        check("restart_pre_count", count, 2);
        @(negedge clk);
        start = 1'b1; valid_in = 1'b1; dist_in = 18'd9; label_in = 2'd3;
        @(posedge clk);
        #1 start = 1'b0; valid_in = 1'b0;
        check("restart_count", count, 0);
        check("restart_list", sorted_list, lst(EMPTY, EMPTY, EMPTY, EMPTY, EMPTY));
        check("restart_in_ready", in_ready, 1);

        // Reset during VOTE abandons the query.
        send(18'd8, 2'd1, 1'b0);
        send(18'd4, 2'd2, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_count", count, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        check("abort_idle", in_ready, 0);
        check("abort_result", result_label, 0);
        check("abort_list", sorted_list, lst(EMPTY, EMPTY, EMPTY, EMPTY, EMPTY));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
